// File: rtl/colour_bbox_detector.sv
// Colour-threshold bounding-box detector for the blurred RGB video stream.
// Optional build macro: DETECT_HIGHLIGHT_EN (paints matching pixels magenta on the passthrough).
module colour_bbox_detector #(
    parameter int IMAGE_W    = 640,
    parameter int IMAGE_H    = 480,
    parameter int MIN_PIXELS = 64,
    parameter int CNT_W      = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       red,
    input  logic [7:0]       green,
    input  logic [7:0]       blue,
    input  logic             in_valid,
    input  logic             sop,
    input  logic             eop,
    input  logic             packet_video,
    input  logic [7:0]       r_min,
    input  logic [7:0]       r_max,
    input  logic [7:0]       g_min,
    input  logic [7:0]       g_max,
    input  logic [7:0]       b_min,
    input  logic [7:0]       b_max,
    output logic [10:0]      bbox_x_min,
    output logic [10:0]      bbox_x_max,
    output logic [10:0]      bbox_y_min,
    output logic [10:0]      bbox_y_max,
    output logic [CNT_W-1:0] match_count,
    output logic             bbox_found,
    output logic             bbox_valid,
    output logic             pix_match,
    output logic [7:0]       red_out,
    output logic [7:0]       green_out,
    output logic [7:0]       blue_out,
    output logic             dbg_state
);

    // Stream handshake: a beat transfers on every clock edge where in_valid is high;
    // there is no backpressure. A sop beat is a header; any other beat is a pixel.
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic [10:0]      X_LAST  = 11'(IMAGE_W - 1);
    localparam logic [10:0]      Y_LAST  = 11'(IMAGE_H - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

    state_t            state;
    logic [10:0]       x, y;
    logic [10:0]       xmin, xmax, ymin, ymax;
    logic [CNT_W-1:0]  cnt;

    logic              match;
    logic              pixel_beat;
    logic              frame_end;
    logic [10:0]       nx_xmin, nx_xmax, nx_ymin, nx_ymax;
    logic [CNT_W-1:0]  nx_cnt;
    logic [7:0]        pix_r, pix_g, pix_b;

    assign dbg_state = state;

    // A channel whose min exceeds its max can never satisfy both bounds.
    assign match = (red   >= r_min) && (red   <= r_max) &&
                   (green >= g_min) && (green <= g_max) &&
                   (blue  >= b_min) && (blue  <= b_max);

    assign pixel_beat = in_valid && !sop;
    assign frame_end  = ((x == X_LAST) && (y == Y_LAST)) || eop;

`ifdef DETECT_HIGHLIGHT_EN
    assign pix_r = match ? 8'hFF : red;
    assign pix_g = match ? 8'h00 : green;
    assign pix_b = match ? 8'hFF : blue;
`else
    assign pix_r = red;
    assign pix_g = green;
    assign pix_b = blue;
`endif

    // Accumulators including the current pixel, so frame end can publish them directly.
    always_comb begin
        nx_xmin = xmin;
        nx_xmax = xmax;
        nx_ymin = ymin;
        nx_ymax = ymax;
        nx_cnt  = cnt;
        if (match) begin
            if (x < xmin) nx_xmin = x;
            if (x > xmax) nx_xmax = x;
            if (y < ymin) nx_ymin = y;
            if (y > ymax) nx_ymax = y;
            if (cnt != CNT_MAX) nx_cnt = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            xmin        <= '1;
            xmax        <= '0;
            ymin        <= '1;
            ymax        <= '0;
            cnt         <= '0;
            bbox_x_min  <= '0;
            bbox_x_max  <= '0;
            bbox_y_min  <= '0;
            bbox_y_max  <= '0;
            match_count <= '0;
            bbox_found  <= 1'b0;
            bbox_valid  <= 1'b0;
            pix_match   <= 1'b0;
            red_out     <= '0;
            green_out   <= '0;
            blue_out    <= '0;
        end else begin
            bbox_valid <= 1'b0;

            if (pixel_beat) begin
                pix_match <= match;
                red_out   <= pix_r;
                green_out <= pix_g;
                blue_out  <= pix_b;
            end

            if (in_valid && sop) begin
                // A header always abandons any frame in progress.
                x     <= '0;
                y     <= '0;
                xmin  <= '1;
                xmax  <= '0;
                ymin  <= '1;
                ymax  <= '0;
                cnt   <= '0;
                state <= packet_video ? ACTIVE : IDLE;
            end else if (pixel_beat && state == ACTIVE) begin
                if (frame_end) begin
                    // Empty frames publish zeros rather than the all-ones min sentinels.
                    bbox_x_min  <= (nx_cnt == '0) ? 11'd0 : nx_xmin;
                    bbox_y_min  <= (nx_cnt == '0) ? 11'd0 : nx_ymin;
                    bbox_x_max  <= nx_xmax;
                    bbox_y_max  <= nx_ymax;
                    match_count <= nx_cnt;
                    bbox_found  <= (nx_cnt >= MIN_CNT);
                    bbox_valid  <= 1'b1;
                    state       <= IDLE;
                end else begin
                    xmin <= nx_xmin;
                    xmax <= nx_xmax;
                    ymin <= nx_ymin;
                    ymax <= nx_ymax;
                    cnt  <= nx_cnt;
                    if (x == X_LAST) begin
                        x <= '0;
                        y <= y + 11'd1;
                    end else begin
                        x <= x + 11'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_colour_bbox_detector.sv
// Bench for colour_bbox_detector on an 8x4 frame with a 4-bit saturating counter.
module tb_colour_bbox_detector;

    localparam int W     = 8;
    localparam int H     = 4;
    localparam int MINP  = 2;
    localparam int CW    = 4;
    localparam int RES_W = 11 * 4 + CW + 1;
    localparam int NPIX  = W * H;
    localparam int NO_EOP = 99;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    red = '0, green = '0, blue = '0;
    logic          in_valid = 1'b0, sop = 1'b0, eop = 1'b0, packet_video = 1'b0;
    logic [7:0]    r_min = 8'd50, r_max = 8'd150;
    logic [7:0]    g_min = 8'd50, g_max = 8'd150;
    logic [7:0]    b_min = 8'd50, b_max = 8'd150;
    logic [10:0]   bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
    logic [CW-1:0] match_count;
    logic          bbox_found, bbox_valid, pix_match;
    logic [7:0]    red_out, green_out, blue_out;
    logic          dbg_state;

    colour_bbox_detector #(
        .IMAGE_W(W), .IMAGE_H(H), .MIN_PIXELS(MINP), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .red(red), .green(green), .blue(blue),
        .in_valid(in_valid), .sop(sop), .eop(eop), .packet_video(packet_video),
        .r_min(r_min), .r_max(r_max), .g_min(g_min), .g_max(g_max),
        .b_min(b_min), .b_max(b_max),
        .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max),
        .bbox_y_min(bbox_y_min), .bbox_y_max(bbox_y_max),
        .match_count(match_count), .bbox_found(bbox_found), .bbox_valid(bbox_valid),
        .pix_match(pix_match),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [RES_W-1:0] exp_q[$];
    logic [RES_W-1:0] last_pub = '0;
    logic [24:0]      last_beat = '0;
    int               checks = 0;
    int               errors = 0;
    logic [7:0]       pr[NPIX], pg[NPIX], pb[NPIX];

    typedef struct {
        string       name;
        logic [7:0]  rmin, rmax;
        logic [31:0] mask;
        int          eop_idx;
        logic [10:0] xmn, xmx, ymn, ymx;
        logic [3:0]  cnt;
        logic        found;
    } vec_t;

    vec_t vecs[7];

    // ---------------- reference model ----------------
    function automatic logic match_ref(input logic [7:0] r, g, b);
        return (r >= r_min && r <= r_max) && (g >= g_min && g <= g_max) &&
               (b >= b_min && b <= b_max);
    endfunction

    function automatic logic [RES_W-1:0] pack_res(input int xmn, xmx, ymn, ymx, cnt);
        return {11'(xmn), 11'(xmx), 11'(ymn), 11'(ymx), 4'(cnt), (cnt >= MINP)};
    endfunction

    // Walks the frame in raster order; the frame ends at the last pixel or at eop.
    function automatic logic [RES_W-1:0] model_frame(input int eop_idx);
        int cnt = 0;
        int xmn = 10000, xmx = -1, ymn = 10000, ymx = -1;
        for (int i = 0; i < NPIX; i++) begin
            int px = i % W;
            int py = i / W;
            if (match_ref(pr[i], pg[i], pb[i])) begin
                cnt = (cnt < (1 << CW) - 1) ? cnt + 1 : cnt;
                if (px < xmn) xmn = px;
                if (px > xmx) xmx = px;
                if (py < ymn) ymn = py;
                if (py > ymx) ymx = py;
            end
            if (i == eop_idx) break;
        end
        if (cnt == 0) return '0;
        return pack_res(xmn, xmx, ymn, ymx, cnt);
    endfunction

    function automatic logic [RES_W-1:0] got_res();
        return {bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, match_count, bbox_found};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%h required=%h at %0t", name, got, want, $time);
        end
    endtask

    // Advances one clock and retires any published result against the expected queue.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bbox_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_bbox_valid", 128'(bbox_valid), 128'(0));
            end else begin
                logic [RES_W-1:0] e;
                e = exp_q.pop_front();
                check("bbox_result", 128'(got_res()), 128'(e));
                last_pub = e;
            end
        end
    endtask

    task automatic check_pub(input string name);
        check(name, 128'(got_res()), 128'(last_pub));
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [7:0] r, g, b, input logic s, e, pv);
        logic pm;
        pm = match_ref(r, g, b);
        red = r; green = g; blue = b;
        sop = s; eop = e; packet_video = pv; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; sop = 1'b0; eop = 1'b0;
        if (!s) begin
            last_beat = {r, g, b, pm};
            check("passthrough", 128'({red_out, green_out, blue_out, pix_match}), 128'(last_beat));
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            tick();
            check("hold_passthrough", 128'({red_out, green_out, blue_out, pix_match}),
                  128'(last_beat));
        end
    endtask

    task automatic run_frame(input logic [RES_W-1:0] exp, input int eop_idx,
                             input bit with_sop, input bit gaps, input int extra);
        exp_q.push_back(exp);
        if (with_sop) send_beat(8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < NPIX; i++) begin
            send_beat(pr[i], pg[i], pb[i], 1'b0, (i == eop_idx), 1'b1);
            if (gaps) idle_cycles($urandom_range(0, 2));
        end
        for (int i = 0; i < extra; i++)
            send_beat(8'd100, 8'd100, 8'd100, 1'b0, 1'b0, 1'b1);
        idle_cycles(2);
        check("strobe_count", 128'(exp_q.size()), 128'(0));
        check_pub("outputs_after_frame");
    endtask

    task automatic load_mask(input logic [31:0] mask);
        for (int i = 0; i < NPIX; i++) begin
            pr[i] = mask[i] ? 8'd100 : 8'd10;
            pg[i] = 8'd100;
            pb[i] = 8'd100;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{"two_px",       8'd50,  8'd150, 32'h2000_0400, NO_EOP, 2, 5, 1, 3, 2,  1'b1};
        vecs[1] = '{"single_7_0",   8'd50,  8'd150, 32'h0000_0080, NO_EOP, 7, 7, 0, 0, 1,  1'b0};
        vecs[2] = '{"min_gt_max",   8'd200, 8'd100, 32'hFFFF_FFFF, NO_EOP, 0, 0, 0, 0, 0,  1'b0};
        vecs[3] = '{"saturate",     8'd50,  8'd150, 32'hFFFF_FFFF, NO_EOP, 0, 7, 0, 3, 15, 1'b1};
        vecs[4] = '{"short_eop",    8'd50,  8'd150, 32'h0010_1008, 12,     3, 4, 0, 1, 2,  1'b1};
        vecs[5] = '{"corners",      8'd50,  8'd150, 32'h8000_0001, NO_EOP, 0, 7, 0, 3, 2,  1'b1};
        vecs[6] = '{"thresh_equal", 8'd100, 8'd100, 32'h0000_0200, NO_EOP, 1, 1, 1, 1, 1,  1'b0};

        // Reset state
        #1;
        check("reset_bbox", 128'({got_res(), bbox_valid}), 128'(0));
        check("reset_pix", 128'({red_out, green_out, blue_out, pix_match, dbg_state}), 128'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle_cycles(2);

        // Table-driven frames
        foreach (vecs[k]) begin
            r_min = vecs[k].rmin;
            r_max = vecs[k].rmax;
            load_mask(vecs[k].mask);
            run_frame(pack_res(vecs[k].xmn, vecs[k].xmx, vecs[k].ymn, vecs[k].ymx, vecs[k].cnt),
                      vecs[k].eop_idx, 1'b1, 1'b0, (k == 4) ? 3 : 0);
        end
        r_min = 8'd50;
        r_max = 8'd150;

        // Non-video packet: matching beats must not publish anything
        send_beat(8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < NPIX; i++) send_beat(8'd100, 8'd100, 8'd100, 1'b0, 1'b0, 1'b0);
        idle_cycles(2);
        check("nonvideo_state", 128'(dbg_state), 128'(0));
        check_pub("nonvideo_hold");

        // Partial frame abandoned by a fresh sop
        send_beat(8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) send_beat(8'd100, 8'd100, 8'd100, 1'b0, 1'b0, 1'b1);
        load_mask(vecs[0].mask);
        run_frame(pack_res(2, 5, 1, 3, 2), NO_EOP, 1'b1, 1'b0, 0);

        // eop on the sop beat is only a header
        send_beat(8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1);
        check("sop_eop_active", 128'(dbg_state), 128'(1));
        load_mask(vecs[1].mask);
        run_frame(pack_res(7, 7, 0, 0, 1), NO_EOP, 1'b0, 1'b0, 0);

        // Reset mid-frame: outputs clear with no clock edge
        send_beat(8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) send_beat(8'd100, 8'd100, 8'd100, 1'b0, 1'b0, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midreset_bbox", 128'({got_res(), bbox_valid}), 128'(0));
        check("midreset_pix", 128'({red_out, green_out, blue_out, pix_match, dbg_state}), 128'(0));
        last_pub = '0;
        last_beat = '0;
        @(negedge clk);
        reset_n = 1'b1;
        idle_cycles(2);
        for (int i = 0; i < NPIX; i++) send_beat(8'd100, 8'd100, 8'd100, 1'b0, 1'b0, 1'b1);
        check_pub("after_reset_no_sop");
        load_mask(vecs[5].mask);
        run_frame(pack_res(0, 7, 0, 3, 2), NO_EOP, 1'b1, 1'b0, 0);

        // Randomized frames against the reference model
        for (int f = 0; f < 8; f++) begin
            logic [7:0] lo[3], hi[3];
            int eidx;
            for (int c = 0; c < 3; c++) begin
                lo[c] = 8'($urandom_range(0, 200));
                hi[c] = 8'($urandom_range(lo[c], 255));
            end
            if (f == 3) begin
                lo[1] = 8'd180;
                hi[1] = 8'd90;
            end
            r_min = lo[0]; r_max = hi[0];
            g_min = lo[1]; g_max = hi[1];
            b_min = lo[2]; b_max = hi[2];
            for (int i = 0; i < NPIX; i++) begin
                logic [7:0] v[3];
                for (int c = 0; c < 3; c++) begin
                    case ($urandom_range(0, 5))
                        0:       v[c] = lo[c];
                        1:       v[c] = hi[c];
                        2:       v[c] = 8'($urandom_range(0, 255));
                        default: v[c] = (lo[c] <= hi[c]) ? 8'($urandom_range(lo[c], hi[c])) : lo[c];
                    endcase
                end
                pr[i] = v[0]; pg[i] = v[1]; pb[i] = v[2];
            end
            eidx = ($urandom_range(0, 2) == 0) ? $urandom_range(0, NPIX - 1) : NO_EOP;
            run_frame(model_frame(eidx), eidx, 1'b1, 1'b1, $urandom_range(0, 3));
        end

        idle_cycles(3);
        check("final_queue_empty", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
